// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and the divide-by-zero quotient pattern.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } div_state_t;

  // Sliced down to the operand width wherever a divide-by-zero result is produced
  localparam logic [63:0] DBZ_QUOTIENT_ALL = '1;

endpackage

// File: rtl/seq_divider_if.sv
// Start/Done handshake and operand/result bus between the control logic
// (master) and the divider unit (slave).
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell shared by the ALU add path and the divider's
// subtractor chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_divider_ripple_subtractor.sv
// Ripple subtractor built from full_adder cells: minuend + ~subtrahend + 1.
// A missing carry-out means the subtraction borrowed.
module seq_divider_ripple_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic [WIDTH-1:0] difference,
  output logic             borrow
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (minuend[i]),
      .b    (~subtrahend[i]),
      .cin  (carry[i]),
      .sum  (difference[i]),
      .cout (carry[i+1])
    );
  end

  assign borrow = ~carry[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// driven by a Start/Done handshake on seq_divider_if.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_t       state;
  logic [CNT_W-1:0] iter_cnt;
  logic [WIDTH:0]   work_a;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] divisor_reg;

  logic [WIDTH:0]   shifted_a;
  logic [WIDTH-1:0] shifted_q;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             take;
  logic [WIDTH:0]   next_a;
  logic [WIDTH-1:0] next_q;

  assign {shifted_a, shifted_q} = {work_a[WIDTH-1:0], work_q, 1'b0};

  seq_divider_ripple_subtractor #(
    .WIDTH (WIDTH + 1)
  ) u_sub (
    .minuend    (shifted_a),
    .subtrahend ({1'b0, divisor_reg}),
    .difference (trial),
    .borrow     (borrow)
  );

  // A bit shifted out of A means the partial remainder already exceeds the divisor
  assign take   = ~borrow | work_a[WIDTH];
  assign next_a = take ? trial : shifted_a;
  assign next_q = {shifted_q[WIDTH-1:1], take};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      iter_cnt        <= '0;
      work_a          <= '0;
      work_q          <= '0;
      divisor_reg     <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        // IDLE and DONE accept requests identically, giving back-to-back operation
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            if (bus.divisor != '0) begin
              state           <= ST_RUN;
              iter_cnt        <= '0;
              work_a          <= '0;
              work_q          <= bus.dividend;
              divisor_reg     <= bus.divisor;
              bus.busy        <= 1'b1;
              bus.div_by_zero <= 1'b0;
            end else begin
              state           <= ST_DONE;
              bus.quotient    <= DBZ_QUOTIENT_ALL[WIDTH-1:0];
              bus.remainder   <= bus.dividend;
              bus.div_by_zero <= 1'b1;
              bus.done        <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          work_a   <= next_a;
          work_q   <= next_q;
          iter_cnt <= iter_cnt + CNT_W'(1);
          if (iter_cnt == LAST_ITER) begin
            state           <= ST_DONE;
            bus.quotient    <= next_q;
            bus.remainder   <= next_a[WIDTH-1:0];
            bus.div_by_zero <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
